// File: rtl/register_transfer_ctrl_pkg.sv
// Shared definitions for the register transfer controller.
// Holds the ctrl codes understood by the attached `register`, the command
// opcodes accepted on the command port, and the controller FSM encodings.
// Imported by the controller, its bit counter and the testbench.
package register_transfer_ctrl_pkg;

  // Ctrl codes for the attached register.
  typedef enum logic [2:0] {
    CTRL_NONE                = 3'd0,
    CTRL_CLR                 = 3'd1,
    CTRL_PARALLEL_LOAD       = 3'd2,
    CTRL_SERIAL_MSB_LOAD     = 3'd3,
    CTRL_SERIAL_LSB_LOAD     = 3'd4,
    CTRL_SHIFT_LOGICAL_LEFT  = 3'd5,
    CTRL_SHIFT_LOGICAL_RIGHT = 3'd6
  } reg_ctrl_e;

  // Command opcodes.
  typedef enum logic [1:0] {
    OP_CLEAR = 2'd0,
    OP_LOAD  = 2'd1,
    OP_TX    = 2'd2,
    OP_RX    = 2'd3
  } op_e;

  // Controller FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/register_transfer_ctrl_transfer_bit_counter.sv
// Bit counter for serial transfers.
// Loads WIDTH on `load`, counts down by one on `dec` and saturates at zero.
// `last` flags the final bit of a transfer (count == 1).
// Ports:
//   clk, async_nreset : clock, asynchronous active-low reset (count -> 0)
//   load              : load the count with WIDTH
//   dec               : decrement the count (ignored at zero)
//   last              : count currently equals 1
module transfer_bit_counter
  import register_transfer_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic async_nreset,
  input  logic load,
  input  logic dec,
  output logic last
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(WIDTH);
    end else if (dec && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign last = (count == CW'(1));

endmodule

// File: rtl/register_transfer_ctrl.sv
// Register transfer controller.
// Sequences one external ctrl-coded load/shift register through whole-word
// operations: clear, parallel load, serial transmit and serial receive.
// One command is accepted at a time over cmd_valid/cmd_ready.
// Ports:
//   clk, async_nreset        : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready      : command handshake (ready only while idle)
//   cmd_op, cmd_msb_first    : opcode and serial bit order (1 = MSB first)
//   cmd_data                 : word for OP_LOAD / OP_TX
//   reg_ctrl                 : ctrl code to the register
//   reg_parallel_data_input  : parallel word to the register
//   reg_serial_data_input    : serial bit to the register
//   reg_data_output          : current register contents
//   ser_in / ser_out         : serial receive / transmit bit
//   ser_strobe               : one serial bit moves this cycle
//   done                     : one-cycle completion pulse
//   rsp_data                 : register contents, meaningful while done = 1
module register_transfer_ctrl
  import register_transfer_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             async_nreset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_msb_first,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [2:0]       reg_ctrl,
  output logic [WIDTH-1:0] reg_parallel_data_input,
  output logic             reg_serial_data_input,
  input  logic [WIDTH-1:0] reg_data_output,
  input  logic             ser_in,
  output logic             ser_out,
  output logic             ser_strobe,
  output logic             done,
  output logic [WIDTH-1:0] rsp_data
);

  state_e           state;
  state_e           state_nxt;
  op_e              op_q;
  logic             msb_q;
  logic [WIDTH-1:0] data_q;
  logic             accept;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_last;

  assign accept = cmd_valid && cmd_ready;

  // Command latch and state register
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      state <= ST_IDLE;
      op_q  <= OP_CLEAR;
      msb_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q  <= op_e'(cmd_op);
        msb_q <= cmd_msb_first;
      end
    end
  end

  // The data word only reaches the register while in LOAD, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_q <= cmd_data;
    end
  end

  transfer_bit_counter #(
    .WIDTH(WIDTH)
  ) u_bit_counter (
    .clk         (clk),
    .async_nreset(async_nreset),
    .load        (cnt_load),
    .dec         (cnt_dec),
    .last        (cnt_last)
  );

  // Next-state logic; the counter is loaded on entry to SHIFT.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (op_e'(cmd_op) == OP_RX) begin
            state_nxt = ST_SHIFT;
            cnt_load  = 1'b1;
          end else begin
            state_nxt = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (op_q == OP_TX) begin
          state_nxt = ST_SHIFT;
          cnt_load  = 1'b1;
        end else begin
          state_nxt = ST_DONE;
        end
      end
      ST_SHIFT: begin
        cnt_dec = 1'b1;
        if (cnt_last) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode from state and latched command fields.
  always_comb begin
    cmd_ready               = 1'b0;
    reg_ctrl                = CTRL_NONE;
    reg_parallel_data_input = '0;
    reg_serial_data_input   = 1'b0;
    ser_out                 = 1'b0;
    ser_strobe              = 1'b0;
    done                    = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
      end
      ST_LOAD: begin
        if (op_q == OP_CLEAR) begin
          reg_ctrl = CTRL_CLR;
        end else begin
          reg_ctrl                = CTRL_PARALLEL_LOAD;
          reg_parallel_data_input = data_q;
        end
      end
      ST_SHIFT: begin
        ser_strobe = 1'b1;
        if (op_q == OP_RX) begin
          // MSB-first arrivals enter at the LSB so the first bit ends up on top.
          reg_ctrl              = msb_q ? CTRL_SERIAL_LSB_LOAD : CTRL_SERIAL_MSB_LOAD;
          reg_serial_data_input = ser_in;
        end else begin
          // Transmit the bit that is about to be shifted out this edge.
          reg_ctrl = msb_q ? CTRL_SHIFT_LOGICAL_LEFT : CTRL_SHIFT_LOGICAL_RIGHT;
          ser_out  = msb_q ? reg_data_output[WIDTH-1] : reg_data_output[0];
        end
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        cmd_ready = 1'b0;
      end
    endcase
  end

  assign rsp_data = reg_data_output;

endmodule
